edge_event_arbiter: RTL and testbench
=====================================

// Module: edge_event_arbiter
// PURPOSE
//  Multi-channel edge-event scheduler. Watches N_CH level inputs and detects
//  rising/falling edges per channel under per-channel mode control. Holds one
//  pending event per channel and shares a single event output port among the
//  channels with round-robin arbitration and a valid/ready handshake.
//  Sits between raw level sources (buttons, status lines) and a single event consumer.
// PARAMETERS
//  N_CH    4                    number of level channels (>=2)
//  CH_W    $clog2(N_CH)         width of channel index (derived, do not override)
// PORTS
//  clk        in   1         clock
//  reset_n    in   1         reset, asynchronous, active-low
//  level      in   N_CH      per-channel level inputs
//  mode       in   2*N_CH    per-channel mode [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//  evt_valid  out  1         output event present
//  evt_ready  in   1         consumer accepts event when evt_valid&evt_ready
//  evt_ch     out  CH_W      channel index of presented event
//  evt_rise   out  1         1 = rising edge, 0 = falling edge
//  ovf        out  N_CH      sticky per-channel overflow (event dropped)
//  ovf_clr    in   1         synchronous clear of all ovf bits
// BEHAVIOUR
//  Reset: evt_valid=0, evt_ch=0, evt_rise=0, ovf=0, all pending=0, rr pointer=0,
//   prev[i]=0, armed=0.
//  armed: 0 during the first cycle after reset. That cycle loads prev=level only;
//   no edges are detected. armed=1 afterwards.
//  Edge: rise_i = armed & level_s[i] & ~prev[i]; fall_i = armed & ~level_s[i] & prev[i].
//   Qualified by mode. prev updates every cycle.
//  Pending: a qualified edge sets pend[i]=1 and pol[i]=rise_i at the next clk.
//   If pend[i] is already 1 and not being granted that cycle: the new edge is
//   dropped, pend/pol are unchanged, and ovf[i] is set.
//  Simultaneous grant and new edge on the same channel: the grant takes the
//   old event, and pend is re-set with the new pol. No ovf.
//  Mode change gates detection only. Existing pending events are kept and issued.
//  Output register: loads when (~evt_valid | evt_ready) and any pend is set.
//   The winner is the first set pend at or after rr_ptr, with modulo-N_CH wrap.
//   On load: evt_valid=1, evt_ch/evt_rise = winner, pend[winner] cleared,
//   rr_ptr = winner+1 (wraps N_CH-1 -> 0).
//  If evt_ready=1 and no pend: evt_valid drops to 0 next cycle.
//  While evt_valid & ~evt_ready: evt_ch/evt_rise are held stable and no grant occurs.
//  Back-to-back: with evt_ready held 1, one event is issued per cycle.
//  Latency: level change sampled at edge k -> pend at k; evt_valid at k+1
//   (1 cycle pend->output when output is free).
//  ovf_clr has priority over a same-cycle set: clear wins, and the event is still dropped.
//  Async reset mid-operation discards all pending and presented events immediately.
// CONFIGURATION
//  EDGE_ARB_SYNC_EN defined: each level bit passes through a 2-flop synchronizer
//   (reset 0) before edge detection, so level_s = sync output. This adds 2 cycles
//   latency. armed stays 0 for the first 3 cycles after reset so synchronizer fill
//   produces no spurious edges.
//  Not defined: level_s = level. Inputs are assumed synchronous to clk.
// STRUCTURE
//  Package edge_arb_pkg: mode encodings MODE_OFF/RISE/FALL/BOTH (2-bit localparams)
//   and a function rr_pick(pend, ptr) returning the winner index.
//  Sub-module edge_chan (one per channel, generate loop): optional synchronizer,
//   prev register, mode qualification, pend/pol/ovf storage.
//   Inputs: grant, ovf_clr, armed.
//  Top level holds armed logic, rr_ptr, the rr_pick arbiter and the output register.
// TESTING
//  1 Reset with level=4'b1111, mode=all BOTH -> no event for 5 cycles; evt_valid=0, ovf=0.
//  2 ch2 mode=RISE, level[2] 0->1, evt_ready=1 -> evt_valid 1 cycle after pend,
//    evt_ch=2, evt_rise=1, single beat. Then 1->0 -> no event.
//  3 ch0,1,3 rise in same cycle, evt_ready=1, rr_ptr=0 -> evt_ch 0,1,3 on
//    consecutive cycles; next grant search starts at 0 (wrap).
//  4 evt_ready=0 with event held; ch1 toggles twice -> evt_ch/evt_rise stable;
//    second ch1 edge sets ovf[1]=1. ovf_clr pulse -> ovf=0.
//  5 Same-cycle grant of ch3 and new fall on ch3 -> next event ch3 evt_rise=0, ovf[3]=0.
//  6 Assert reset_n=0 while evt_valid=1 and 2 events are pending -> evt_valid=0
//    immediately; after release no stale events are issued.
//    Repeat 1-3 with EDGE_ARB_SYNC_EN: latency +2 cycles.

Source files
------------

// File: rtl/edge_arb_pkg.sv
// Shared encodings and the round-robin pick helper for edge_event_arbiter.
package edge_arb_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // Widest channel count rr_pick can search; callers zero-extend pend.
    localparam int MAX_CH = 32;

    // First set bit of pend at or after ptr, wrapping modulo n.
    function automatic int rr_pick(input logic [MAX_CH-1:0] pend, input int ptr, input int n);
        int   idx;
        logic found;
        rr_pick = 0;
        found   = 1'b0;
        for (int k = 0; k < MAX_CH; k++) begin
            idx = ptr + k;
            if (idx >= n) idx = idx - n;
            if (k < n && !found && pend[idx[4:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: optional level synchronizer, edge detect, mode gating and the
// single-entry pending event with sticky overflow. EDGE_ARB_SYNC_EN adds the synchronizer.
module edge_chan
    import edge_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       level,
    input  logic [1:0] mode,
    input  logic       armed,
    input  logic       grant,
    input  logic       ovf_clr,
    output logic       pend,
    output logic       pol,
    output logic       ovf
);

    logic level_s;
    logic prev;
    logic rise_q, fall_q, edge_q;

`ifdef EDGE_ARB_SYNC_EN
    logic [1:0] sync;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[0], level};
    end
    assign level_s = sync[1];
`else
    assign level_s = level;
`endif

    assign rise_q = armed & level_s & ~prev & (mode == MODE_RISE || mode == MODE_BOTH);
    assign fall_q = armed & ~level_s & prev & (mode == MODE_FALL || mode == MODE_BOTH);
    assign edge_q = rise_q | fall_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= 1'b0;
            pend <= 1'b0;
            pol  <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            prev <= level_s;
            // A grant frees the slot, so a coincident edge refills it without loss.
            if (grant) begin
                pend <= edge_q;
                if (edge_q) pol <= rise_q;
            end else if (edge_q && !pend) begin
                pend <= 1'b1;
                pol  <= rise_q;
            end
            if (ovf_clr)                       ovf <= 1'b0;
            else if (edge_q && pend && !grant) ovf <= 1'b1;
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge-event scheduler with round-robin output arbitration.
// Define EDGE_ARB_SYNC_EN to synchronize level inputs (2 flops) before detection.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_CH-1:0]   level,
    input  logic [2*N_CH-1:0] mode,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_rise,
    output logic [N_CH-1:0]   ovf,
    input  logic              ovf_clr
);

`ifdef EDGE_ARB_SYNC_EN
    localparam logic [1:0] ARM_CYC = 2'd3;
`else
    localparam logic [1:0] ARM_CYC = 2'd1;
`endif

    logic [1:0]        arm_cnt;
    logic              armed;
    logic [N_CH-1:0]   pend, pol, grant;
    logic [MAX_CH-1:0] pend_ext;
    logic [CH_W-1:0]   rr_ptr, winner;
    logic              load;

    // Detection stays off until prev (and any synchronizer) holds real samples.
    assign armed = (arm_cnt == ARM_CYC);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    arm_cnt <= '0;
        else if (!armed) arm_cnt <= arm_cnt + 2'd1;
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        edge_chan u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .level   (level[i]),
            .mode    (mode[2*i+1:2*i]),
            .armed   (armed),
            .grant   (grant[i]),
            .ovf_clr (ovf_clr),
            .pend    (pend[i]),
            .pol     (pol[i]),
            .ovf     (ovf[i])
        );
    end

    assign pend_ext = MAX_CH'(pend);
    assign winner   = CH_W'(rr_pick(pend_ext, int'(rr_ptr), N_CH));
    assign load     = (~evt_valid | evt_ready) & (|pend);

    always_comb begin
        grant = '0;
        if (load) grant[winner] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_rise  <= 1'b0;
            rr_ptr    <= '0;
        end else if (load) begin
            evt_valid <= 1'b1;
            evt_ch    <= winner;
            evt_rise  <= pol[winner];
            rr_ptr    <= (winner == CH_W'(N_CH - 1)) ? '0 : winner + 1'b1;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: cycle-exact vector tables, hand
// sequences for multi-cycle corners, and an in-order scoreboard of accepted events.
module tb_edge_event_arbiter;

`ifdef EDGE_ARB_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] level = 4'b1111;
    logic [7:0] mode = 8'hFF;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [1:0] evt_ch;
    logic       evt_rise;
    logic [3:0] ovf;
    logic       ovf_clr = 1'b0;

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .level     (level),
        .mode      (mode),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ch    (evt_ch),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] level;
        logic [7:0] mode;
        logic       exp_valid;
        logic [1:0] exp_ch;
        logic       exp_rise;
    } vec_t;

    typedef struct {
        logic [1:0] ch;
        logic       rise;
    } evt_t;

    vec_t tbl[32];
    evt_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] ch, input logic rise);
        evt_t e;
        e.ch   = ch;
        e.rise = rise;
        sb.push_back(e);
    endtask

    // Accepted beats are judged against the scoreboard in order.
    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", {evt_ch, evt_rise}, 32'hFFFF);
            end else begin
                evt_t e;
                e = sb.pop_front();
                chk("sb_ch", evt_ch, e.ch);
                chk("sb_rise", evt_rise, e.rise);
            end
        end
    end

    task automatic fill(input int lo, input int hi, input logic [3:0] lv, input logic [7:0] md);
        for (int i = lo; i <= hi; i++) begin
            tbl[i].level     = lv;
            tbl[i].mode      = md;
            tbl[i].exp_valid = 1'b0;
            tbl[i].exp_ch    = 2'd0;
            tbl[i].exp_rise  = 1'b0;
        end
    endtask

    task automatic expect_at(input int idx, input logic [1:0] ch, input logic rise);
        tbl[idx].exp_valid = 1'b1;
        tbl[idx].exp_ch    = ch;
        tbl[idx].exp_rise  = rise;
    endtask

    task automatic run_tbl(input int n);
        for (int i = 0; i < n; i++) begin
            level = tbl[i].level;
            mode  = tbl[i].mode;
            step();
            chk($sformatf("tbl%0d_valid", i), evt_valid, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_ovf", i), ovf, 4'b0);
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_ch", i), evt_ch, tbl[i].exp_ch);
                chk($sformatf("tbl%0d_rise", i), evt_rise, tbl[i].exp_rise);
            end
        end
    endtask

    task automatic reset_dut();
        reset_n   = 1'b0;
        level     = 4'b1111;
        mode      = 8'hFF;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        #1;
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_ovf", ovf, 4'b0);
        chk("rst_ch", evt_ch, 2'd0);
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    initial begin
        // 1: steady high levels with BOTH mode produce nothing after reset
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t1_valid", evt_valid, 1'b0);
            chk("t1_ovf", ovf, 4'b0);
        end

        // 2: ch2 RISE only; a rise gives one beat, the later fall gives none
        fill(0, 0, 4'b1011, 8'h10);
        fill(1, 4, 4'b1111, 8'h10);
        fill(5, 9, 4'b1011, 8'h10);
        expect_at(2 + SL, 2'd2, 1'b1);
        push(2'd2, 1'b1);
        run_tbl(10);

        // 3: ch0/1/3 rise together, round robin from 0, then wrap back to 0
        reset_dut();
        repeat (4) step();
        fill(0, 2, 4'b0100, 8'h55);
        fill(3, 7, 4'b1111, 8'h55);
        fill(8, 10, 4'b0100, 8'h55);
        fill(11, 19, 4'b1101, 8'h55);
        expect_at(4 + SL, 2'd0, 1'b1);
        expect_at(5 + SL, 2'd1, 1'b1);
        expect_at(6 + SL, 2'd3, 1'b1);
        expect_at(12 + SL, 2'd0, 1'b1);
        expect_at(13 + SL, 2'd3, 1'b1);
        push(2'd0, 1'b1); push(2'd1, 1'b1); push(2'd3, 1'b1);
        push(2'd0, 1'b1); push(2'd3, 1'b1);
        run_tbl(20);

        // 4: stalled output holds; second ch1 edge overflows; clear wins over set
        evt_ready = 1'b0;
        mode      = 8'hFF;
        level     = 4'b1001;
        push(2'd2, 1'b0);
        repeat (2 + SL) step();
        chk("t4_valid", evt_valid, 1'b1);
        chk("t4_ch", evt_ch, 2'd2);
        chk("t4_rise", evt_rise, 1'b0);
        level = 4'b1011;
        repeat (1 + SL) step();
        chk("t4_hold_ch_a", evt_ch, 2'd2);
        chk("t4_ovf_first", ovf, 4'b0000);
        level = 4'b1001;
        repeat (1 + SL) step();
        chk("t4_hold_ch_b", evt_ch, 2'd2);
        chk("t4_hold_rise", evt_rise, 1'b0);
        chk("t4_ovf_set", ovf, 4'b0010);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr", ovf, 4'b0000);
        level = 4'b1011;
        for (int s = 0; s <= SL; s++) begin
            ovf_clr = (s == SL);
            step();
        end
        ovf_clr = 1'b0;
        chk("t4_clr_priority", ovf, 4'b0000);
        chk("t4_valid_held", evt_valid, 1'b1);
        push(2'd1, 1'b1);
        evt_ready = 1'b1;
        repeat (3) step();
        chk("t4_drained", evt_valid, 1'b0);

        // 5: grant of ch3 coincides with a new ch3 edge; both issue, no overflow
        level = 4'b0011;
        push(2'd3, 1'b0);
        repeat (3 + SL) step();
        chk("t5_idle", evt_valid, 1'b0);
        push(2'd3, 1'b1);
        push(2'd3, 1'b0);
        level = 4'b1011;
        step();
        level = 4'b0011;
        step();
        repeat (SL) step();
        chk("t5_first_ch", evt_ch, 2'd3);
        chk("t5_first_rise", evt_rise, 1'b1);
        step();
        chk("t5_second_valid", evt_valid, 1'b1);
        chk("t5_second_ch", evt_ch, 2'd3);
        chk("t5_second_rise", evt_rise, 1'b0);
        chk("t5_ovf", ovf, 4'b0000);
        step();
        chk("t5_drained", evt_valid, 1'b0);

        // 6: async reset while an event is presented and others are pending
        evt_ready = 1'b0;
        level     = 4'b1100;
        repeat (2 + SL) step();
        chk("t6_valid_pre", evt_valid, 1'b1);
        chk("t6_ch_pre", evt_ch, 2'd0);
        chk("t6_rise_pre", evt_rise, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t6_valid_rst", evt_valid, 1'b0);
        chk("t6_ovf_rst", ovf, 4'b0000);
        evt_ready = 1'b1;
        repeat (2) step();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_no_stale", evt_valid, 1'b0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
